// File: rtl/cnn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cnn_pkg : shared pixel/window types for the CNN front end
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package cnn_pkg;

    typedef bit [15:0] fixedPoint;

    localparam int KSIZE = 5;

    typedef fixedPoint window_t [KSIZE-1:0][KSIZE-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_buffer_ram : one-row circular pixel store, async read / sync write
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module line_buffer_ram
    import cnn_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  fixedPoint       wdata,
    output fixedPoint       rdata
);

    fixedPoint mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Combinational read sees the pre-write contents when addr is written this cycle.
    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/window_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// window_line_buffer : streams a frame in, emits every stride-1 5x5 window
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
import cnn_pkg::*;

module window_line_buffer #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int KSIZE = cnn_pkg::KSIZE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output window_t     window,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int NTAPS = KSIZE - 1;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    window_t            sr;
    window_t            sr_next;
    fixedPoint          taps [NTAPS];
    logic               accept;
    logic               consume;
    logic               emit;
    logic               last_pix;

    assign pix_ready = (state == ST_RUN) && !(win_valid && !win_ready);
    assign accept    = pix_valid && pix_ready;
    assign consume   = win_valid && win_ready;
    assign emit      = (row >= ROW_W'(KSIZE-1)) && (col >= COL_W'(KSIZE-1));
    assign last_pix  = (row == ROW_W'(IMG_H-1)) && (col == COL_W'(IMG_W-1));

    // Tap k holds the pixel k+1 rows above the current one at this column.
    for (genvar k = 0; k < NTAPS; k++) begin : g_lb
        fixedPoint wdata;
        if (k == 0) begin : g_head
            assign wdata = pix_in;
        end else begin : g_chain
            assign wdata = taps[k-1];
        end
        line_buffer_ram #(
            .DEPTH (IMG_W),
            .AW    (COL_W)
        ) u_ram (
            .clk   (clk),
            .we    (accept),
            .addr  (col),
            .wdata (wdata),
            .rdata (taps[k])
        );
    end

    always_comb begin
        sr_next = sr;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE-1; j++) begin
                sr_next[i][j] = sr[i][j+1];
            end
        end
        for (int i = 0; i < KSIZE-1; i++) begin
            sr_next[i][KSIZE-1] = taps[KSIZE-2-i];
        end
        sr_next[KSIZE-1][KSIZE-1] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sr <= sr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            window     <= '{default: '0};
        end else begin
            frame_done <= 1'b0;

            if (accept && emit) begin
                window    <= sr_next;
                win_valid <= 1'b1;
            end else if (consume) begin
                win_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col == COL_W'(IMG_W-1)) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                        if (last_pix) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!win_valid || consume) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_window_line_buffer : directed self-checking bench, 8x8 frame, pixel = r*8+c
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_window_line_buffer;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        win_ready = 1'b1;
    logic [15:0] pix_in = '0;
    logic        pix_ready;
    logic        win_valid;
    logic        frame_done;
    cnn_pkg::window_t win;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cyc = 0;
    int last_acc_cyc = 0;
    int acc36 = 0;
    logic [399:0] win_q [$];
    int           win_cyc_q [$];

    always #5 clk = ~clk;

    window_line_buffer #(
        .IMG_W (W),
        .IMG_H (H),
        .KSIZE (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .window     (win),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    function automatic logic [399:0] flat_dut();
        logic [399:0] f;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                f[(i*5+j)*16 +: 16] = win[i][j];
        return f;
    endfunction

    // Window whose newest pixel sits at (r, c).
    function automatic logic [399:0] exp_win(input int r, input int c);
        logic [399:0] f;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                f[(i*5+j)*16 +: 16] = 16'((r-4+i)*W + (c-4+j));
        return f;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Records every window at the cycle it is consumed.
    always @(negedge clk) begin
        if (win_valid && win_ready) begin
            win_q.push_back(flat_dut());
            win_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
    end

    task automatic clear_q();
        win_q.delete();
        win_cyc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pixel(input int v, input bit gap);
        int guard = 0;
        pix_in    = 16'(v);
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!pix_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout pixel %0d got pix_ready=%b required 1", v, pix_ready);
        end
        last_acc_cyc = cyc;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input bit gap, input int start_at);
        int d0 = done_count;
        int guard = 0;
        pulse_start();
        for (int p = 0; p < W*H; p++) begin
            if (p == start_at) pulse_start();
            send_pixel(p, gap);
            if (p == 36) acc36 = last_acc_cyc;
        end
        while (done_count == d0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (done_count == d0) begin
            checks++; errors++;
            $display("FAIL done_timeout got done_count=%0d required %0d", done_count, d0 + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready got %b required 0", pix_ready); end
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rst_win_valid got %b required 0", win_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b required 0", frame_done); end
        checks++; if (flat_dut() !== '0) begin errors++; $display("FAIL rst_window got %h required 0", flat_dut()); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        clear_q();
        run_frame(1'b0, -1);
        checks++;
        if (win_q.size() != 16) begin
            errors++; $display("FAIL full_count got %0d required 16", win_q.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (win_q[k] !== exp_win(4 + k/4, 4 + k%4)) begin
                    errors++; $display("FAIL full_win%0d got %h required %h", k, win_q[k], exp_win(4 + k/4, 4 + k%4));
                end
            end
            checks++; if (win_cyc_q[0] != acc36 + 1) begin errors++; $display("FAIL first_latency got cycle %0d required %0d", win_cyc_q[0], acc36 + 1); end
            checks++; if (win_q[0][15:0] !== 16'd0) begin errors++; $display("FAIL first_w00 got %0d required 0", win_q[0][15:0]); end
            checks++; if (win_q[15][399:384] !== 16'd63) begin errors++; $display("FAIL last_w44 got %0d required 63", win_q[15][399:384]); end
            checks++; if (done_cyc != win_cyc_q[15] + 1) begin errors++; $display("FAIL done_timing got cycle %0d required %0d", done_cyc, win_cyc_q[15] + 1); end
        end
    endtask

    // Relies on the queue left by test_full_frame.
    task automatic test_row_wrap();
        checks++;
        if (win_q.size() < 5) begin
            errors++; $display("FAIL wrap_count got %0d required >=5", win_q.size());
        end else begin
            checks++; if (win_q[3][399:384] !== 16'd39) begin errors++; $display("FAIL wrap_prev_w44 got %0d required 39", win_q[3][399:384]); end
            checks++; if (win_q[4][399:384] !== 16'd44) begin errors++; $display("FAIL wrap_next_w44 got %0d required 44", win_q[4][399:384]); end
            checks++; if (win_q[4][15:0] !== 16'd8) begin errors++; $display("FAIL wrap_next_w00 got %0d required 8", win_q[4][15:0]); end
        end
    endtask

    task automatic stall_ctrl();
        int guard = 0;
        while (!(win_valid && win[4][4] == 16'd37) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) begin
            checks++; errors++;
            $display("FAIL stall_wait got win_valid=%b required window 37", win_valid);
        end
        win_ready = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            checks++; if (flat_dut() !== exp_win(4, 5)) begin errors++; $display("FAIL stall_window%0d got %h required %h", n, flat_dut(), exp_win(4, 5)); end
            checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL stall_pix_ready%0d got %b required 0", n, pix_ready); end
            checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL stall_win_valid%0d got %b required 1", n, win_valid); end
            @(posedge clk); #1;
        end
        win_ready = 1'b1;
    endtask

    task automatic test_stall();
        clear_q();
        fork
            run_frame(1'b0, -1);
            stall_ctrl();
        join
        checks++;
        if (win_q.size() != 16) begin
            errors++; $display("FAIL stall_count got %0d required 16", win_q.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (win_q[k] !== exp_win(4 + k/4, 4 + k%4)) begin
                    errors++; $display("FAIL stall_win%0d got %h required %h", k, win_q[k], exp_win(4 + k/4, 4 + k%4));
                end
            end
            checks++; if (win_q[2][399:384] !== 16'd38) begin errors++; $display("FAIL stall_next_w44 got %0d required 38", win_q[2][399:384]); end
        end
    endtask

    task automatic test_toggle();
        clear_q();
        run_frame(1'b1, -1);
        checks++;
        if (win_q.size() != 16) begin
            errors++; $display("FAIL toggle_count got %0d required 16", win_q.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (win_q[k] !== exp_win(4 + k/4, 4 + k%4)) begin
                    errors++; $display("FAIL toggle_win%0d got %h required %h", k, win_q[k], exp_win(4 + k/4, 4 + k%4));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pts [2] = '{20, 37};
        for (int t = 0; t < 2; t++) begin
            int n = pts[t];
            int d0;
            clear_q();
            win_ready = (n < 37);
            pulse_start();
            for (int p = 0; p < n; p++) send_pixel(p, 1'b0);
            checks++; if (win_valid !== (n >= 37)) begin errors++; $display("FAIL pre_rst_valid_%0d got %b required %b", n, win_valid, n >= 37); end
            d0 = done_count;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid_%0d got %b required 0", n, win_valid); end
            checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_%0d got %b required 0", n, pix_ready); end
            repeat (4) @(posedge clk);
            #1;
            checks++; if (done_count != d0) begin errors++; $display("FAIL mid_rst_done_%0d got %0d required %0d", n, done_count, d0); end
            win_ready = 1'b1;
        end
        clear_q();
        run_frame(1'b0, -1);
        checks++;
        if (win_q.size() != 16) begin
            errors++; $display("FAIL after_rst_count got %0d required 16", win_q.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (win_q[k] !== exp_win(4 + k/4, 4 + k%4)) begin
                    errors++; $display("FAIL after_rst_win%0d got %h required %h", k, win_q[k], exp_win(4 + k/4, 4 + k%4));
                end
            end
        end
    endtask

    task automatic test_ignore();
        int n0;
        clear_q();
        run_frame(1'b0, 10);
        checks++;
        if (win_q.size() != 16) begin
            errors++; $display("FAIL ignore_count got %0d required 16", win_q.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (win_q[k] !== exp_win(4 + k/4, 4 + k%4)) begin
                    errors++; $display("FAIL ignore_win%0d got %h required %h", k, win_q[k], exp_win(4 + k/4, 4 + k%4));
                end
            end
        end
        n0 = win_q.size();
        pix_in    = 16'h0055;
        pix_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL idle_pix_ready%0d got %b required 0", c, pix_ready); end
            checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL idle_win_valid%0d got %b required 0", c, win_valid); end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        checks++; if (win_q.size() != n0) begin errors++; $display("FAIL idle_count got %0d required %0d", win_q.size(), n0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_row_wrap();
        test_stall();
        test_toggle();
        test_reset_mid();
        test_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
